// File: rtl/thumb_prefetch_buf_pkg.sv
// rtl/thumb_prefetch_buf_pkg.sv - Thumb-2 fetch constants, request states and length decode
package thumb_fetch_pkg;

  localparam int DEFAULT_DEPTH = 4;

  // Leading hw0[15:11] patterns that introduce a 32-bit Thumb-2 encoding
  localparam logic [4:0] T32_PFX_0 = 5'b11101;
  localparam logic [4:0] T32_PFX_1 = 5'b11110;
  localparam logic [4:0] T32_PFX_2 = 5'b11111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } req_state_t;

  function automatic logic is_thumb32(input logic [15:0] hw);
    return (hw[15:11] == T32_PFX_0) || (hw[15:11] == T32_PFX_1) ||
           (hw[15:11] == T32_PFX_2);
  endfunction

endpackage

// File: rtl/thumb_prefetch_buf_if.sv
// rtl/thumb_prefetch_buf_if.sv - memory, redirect and instruction handshake bundle
interface thumb_prefetch_buf_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_is32;
  logic [31:0] inst_pc;
  logic        inst_ready;

  // master: the prefetch buffer; slave: memory plus fetch stage
  modport master (
    output mem_req, mem_addr, inst_valid, inst, inst_is32, inst_pc,
    input  mem_rvalid, mem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst, inst_is32, inst_pc,
    output mem_rvalid, mem_rdata, redirect, redirect_pc, inst_ready
  );

endinterface

// File: rtl/thumb_prefetch_buf_hw_queue.sv
// rtl/thumb_prefetch_buf_hw_queue.sv - circular halfword FIFO, up to 2 pushes and 2 pops per cycle
module hw_queue
  import thumb_fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic [1:0]    push_cnt,
  input  logic [15:0]   push_hw0,
  input  logic [15:0]   push_hw1,
  input  logic [1:0]    pop_cnt,
  output logic [CW-1:0] count,
  output logic [15:0]   hw0,
  output logic [15:0]   hw1
);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_cnt);
      rd_ptr <= rd_ptr + AW'(pop_cnt);
      count  <= count + CW'(push_cnt) - CW'(pop_cnt);
    end
  end

  // Storage needs no reset; entries are only read once count covers them
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (push_cnt != 2'd0) mem[wr_ptr] <= push_hw0;
      if (push_cnt == 2'd2) mem[wr_ptr + AW'(1)] <= push_hw1;
    end
  end

  assign hw0 = mem[rd_ptr];
  assign hw1 = mem[rd_ptr + AW'(1)];

endmodule

// File: rtl/thumb_prefetch_buf.sv
// rtl/thumb_prefetch_buf.sv - word fetcher feeding a halfword queue that emits whole Thumb-2 instructions
module thumb_prefetch_buf
  import thumb_fetch_pkg::*;
#(
  parameter int          DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  thumb_prefetch_buf_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  req_state_t    state, state_n;
  logic          discard, discard_n;
  logic          drop_low, drop_low_n;
  logic [31:0]   fetch_addr, fetch_addr_n;
  logic          req_issue;
  logic          mem_req_q;
  logic [31:0]   mem_addr_q;
  logic [31:0]   pc;

  logic [1:0]    push_cnt;
  logic [15:0]   push_hw0;
  logic [15:0]   push_hw1;
  logic [1:0]    pop_cnt;
  logic [CW-1:0] count;
  logic [15:0]   hw0;
  logic [15:0]   hw1;

  logic          head_is32;
  logic          head_ok;
  logic          valid;

  hw_queue #(.DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .clear    (bus.redirect),
    .push_cnt (push_cnt),
    .push_hw0 (push_hw0),
    .push_hw1 (push_hw1),
    .pop_cnt  (pop_cnt),
    .count    (count),
    .hw0      (hw0),
    .hw1      (hw1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      discard    <= 1'b0;
      drop_low   <= RESET_PC[1];
      fetch_addr <= RESET_PC & ~32'h3;
    end else begin
      state      <= state_n;
      discard    <= discard_n;
      drop_low   <= drop_low_n;
      fetch_addr <= fetch_addr_n;
    end
  end

  always_comb begin
    state_n      = state;
    discard_n    = discard;
    drop_low_n   = drop_low;
    fetch_addr_n = fetch_addr;
    req_issue    = 1'b0;
    push_cnt     = 2'd0;
    push_hw0     = 16'h0000;
    push_hw1     = 16'h0000;

    case (state)
      ST_IDLE: begin
        if (!bus.redirect && (count <= CW'(DEPTH - 2))) begin
          req_issue    = 1'b1;
          state_n      = ST_WAIT;
          fetch_addr_n = fetch_addr + 32'd4;
        end
      end
      ST_WAIT: begin
        if (bus.mem_rvalid) begin
          state_n = ST_IDLE;
          if (discard) begin
            discard_n = 1'b0;
          end else if (!bus.redirect) begin
            if (drop_low) begin
              push_cnt   = 2'd1;
              push_hw0   = bus.mem_rdata[31:16];
              drop_low_n = 1'b0;
            end else begin
              push_cnt = 2'd2;
              push_hw0 = bus.mem_rdata[15:0];
              push_hw1 = bus.mem_rdata[31:16];
            end
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // A response landing in the redirect cycle is consumed and dropped here,
    // so only a still-pending one needs the discard flag
    if (bus.redirect) begin
      fetch_addr_n = bus.redirect_pc & ~32'h3;
      drop_low_n   = bus.redirect_pc[1];
      discard_n    = (state == ST_WAIT) && !bus.mem_rvalid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0;
    end else begin
      mem_req_q <= req_issue;
      if (req_issue) mem_addr_q <= fetch_addr;
    end
  end

  assign head_is32 = is_thumb32(hw0);
  assign head_ok   = (count >= CW'(2)) || ((count == CW'(1)) && !head_is32);
  assign valid     = head_ok && !bus.redirect;
  assign pop_cnt   = (valid && bus.inst_ready) ? (head_is32 ? 2'd2 : 2'd1) : 2'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (bus.redirect) begin
      pc <= bus.redirect_pc & ~32'h1;
    end else if (pop_cnt != 2'd0) begin
      pc <= pc + (head_is32 ? 32'd4 : 32'd2);
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.inst_valid = valid;
  assign bus.inst_is32  = valid && head_is32;
  assign bus.inst       = !valid ? 32'h0 : (head_is32 ? {hw0, hw1} : {hw0, 16'h0000});
  assign bus.inst_pc    = valid ? pc : 32'h0;

endmodule

// File: tb/tb_thumb_prefetch_buf.sv
// tb/tb_thumb_prefetch_buf.sv - bench for thumb_prefetch_buf with memory responder and instruction-stream model
module tb_thumb_prefetch_buf;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  thumb_prefetch_buf_if bus();

  thumb_prefetch_buf #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] img [256];
  int          lat = 1;
  bit          pend = 0;
  logic [31:0] pend_addr = 0;
  int          pend_cnt = 0;
  int          req_cnt = 0;
  logic [31:0] deliv_end = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [7:0] ix;
    logic [7:0] ix1;
    ix  = a[8:1];
    ix1 = ix + 8'd1;
    return {img[ix1], img[ix]};
  endfunction

  function automatic bit model_is32(input logic [15:0] hw);
    return (hw >> 11) >= 16'd29;
  endfunction

  // Memory: answers each request after lat cycles and checks request legality
  initial begin
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    forever begin
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = word_at(pend_addr);
          pend = 0;
          if (pend_addr + 32'd4 > deliv_end) deliv_end = pend_addr + 32'd4;
        end else begin
          pend_cnt--;
        end
      end
      if (bus.mem_req === 1'b1) begin
        n_total++;
        if (bus.mem_addr[1:0] === 2'b00 && !pend) n_pass++;
        else $display("FAIL mem_protocol: addr=%h still_pending=%0d required aligned and none pending", bus.mem_addr, pend);
        pend      = 1;
        pend_addr = bus.mem_addr;
        pend_cnt  = lat - 1;
        req_cnt++;
      end
    end
  end

  task automatic fill_img(input bit allow32);
    for (int i = 0; i < 256; i++) begin
      logic [15:0] h;
      h = 16'($urandom);
      if (!allow32) h[15] = 1'b0;
      else if ($urandom_range(3) == 0) h[15:11] = 5'(29 + $urandom_range(2));
      img[i] = h;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.inst_ready = 1'b0;
    pend = 0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    deliv_end = 0;
  endtask

  task automatic run_stream(input int n_inst, input int ready_pct, input int redir_pct,
                            input logic [31:0] start_pc, input bit chk_early, input string name);
    logic [31:0] exp_pc;
    logic [7:0]  ix;
    logic [7:0]  ix1;
    logic [15:0] h0, h1;
    logic [31:0] e_inst;
    bit          e32;
    int          got = 0;
    int          cyc = 0;
    exp_pc = start_pc;
    while (got < n_inst && cyc < 4000) begin
      @(posedge clk); #1;
      bus.inst_ready = ($urandom_range(99) < ready_pct);
      bus.redirect   = (redir_pct > 0) && ($urandom_range(99) < redir_pct);
      if (bus.redirect) bus.redirect_pc = {23'h0, 9'($urandom_range(511))};
      @(negedge clk);
      cyc++;
      if (!bus.inst_valid) begin
        n_total++;
        if (bus.inst === 32'h0 && bus.inst_is32 === 1'b0 && bus.inst_pc === 32'h0) n_pass++;
        else $display("FAIL %s idle_zero: inst=%h is32=%b pc=%h required all zero", name, bus.inst, bus.inst_is32, bus.inst_pc);
      end
      if (bus.redirect) begin
        n_total++;
        if (bus.inst_valid === 1'b0) n_pass++;
        else $display("FAIL %s redirect_valid: inst_valid=%b required 0", name, bus.inst_valid);
        exp_pc = bus.redirect_pc & ~32'h1;
      end else if (bus.inst_valid === 1'b1) begin
        ix  = exp_pc[8:1];
        ix1 = ix + 8'd1;
        h0  = img[ix];
        h1  = img[ix1];
        e32 = model_is32(h0);
        e_inst = e32 ? {h0, h1} : {h0, 16'h0000};
        if (chk_early) begin
          n_total++;
          if (exp_pc + (e32 ? 32'd4 : 32'd2) <= deliv_end) n_pass++;
          else $display("FAIL %s early_valid: pc=%h presented before its halfwords arrived (delivered up to %h)", name, exp_pc, deliv_end);
        end
        n_total++;
        if (bus.inst === e_inst && bus.inst_is32 === e32 && bus.inst_pc === exp_pc) n_pass++;
        else $display("FAIL %s head: inst=%h is32=%b pc=%h required inst=%h is32=%b pc=%h",
                      name, bus.inst, bus.inst_is32, bus.inst_pc, e_inst, e32, exp_pc);
        if (bus.inst_ready) begin
          exp_pc = exp_pc + (e32 ? 32'd4 : 32'd2);
          got++;
        end
      end
    end
    n_total++;
    if (got >= n_inst) n_pass++;
    else $display("FAIL %s timeout: accepted %0d required %0d", name, got, n_inst);
    @(posedge clk); #1;
    bus.inst_ready = 1'b0;
    bus.redirect   = 1'b0;
  endtask

  task automatic test_reset();
    bit seen = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (bus.mem_req === 1'b0 && bus.inst_valid === 1'b0 && bus.inst === 32'h0 &&
        bus.inst_is32 === 1'b0 && dut.count === '0) n_pass++;
    else $display("FAIL reset_state: mem_req=%b valid=%b inst=%h is32=%b count=%0d required all 0",
                  bus.mem_req, bus.inst_valid, bus.inst, bus.inst_is32, dut.count);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) seen = 1;
    end
    n_total++;
    if (seen && bus.mem_addr === 32'h0) n_pass++;
    else $display("FAIL reset_first_req: seen=%0d addr=%h required 1 and 00000000", seen, bus.mem_addr);
  endtask

  task automatic test_16bit();
    fill_img(0);
    img[0] = 16'h2001;
    img[1] = 16'hBF08;
    lat = 1;
    do_reset();
    run_stream(8, 100, 0, 32'h0, 1, "t16");
  endtask

  task automatic test_32bit();
    fill_img(0);
    img[0] = 16'hF7FF;
    img[1] = 16'hF000;
    lat = 1;
    do_reset();
    run_stream(6, 100, 0, 32'h0, 1, "t32");
  endtask

  task automatic test_split();
    fill_img(0);
    img[0] = 16'h2001;
    img[1] = 16'hF7FF;
    img[2] = 16'hF000;
    lat = 3;
    do_reset();
    run_stream(6, 100, 0, 32'h0, 1, "split");
  endtask

  task automatic test_redirect();
    bit seen = 0;
    fill_img(1);
    img[0]    = 16'h1111;
    img[1]    = 16'h2222;
    img[8'h83] = 16'h4444;
    lat = 3;
    do_reset();
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) seen = 1;
    end
    @(posedge clk); #1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h106;
    @(negedge clk);
    n_total++;
    if (bus.inst_valid === 1'b0) n_pass++;
    else $display("FAIL redir_force: inst_valid=%b required 0", bus.inst_valid);
    @(posedge clk); #1;
    bus.redirect = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) seen = 1;
    end
    n_total++;
    if (seen && bus.mem_addr === 32'h104) n_pass++;
    else $display("FAIL redir_addr: seen=%0d addr=%h required 1 and 00000104", seen, bus.mem_addr);
    run_stream(20, 100, 0, 32'h106, 0, "redir");
  endtask

  task automatic test_backpressure();
    int r0;
    fill_img(1);
    lat = 1;
    do_reset();
    r0 = req_cnt;
    repeat (10) @(negedge clk);
    n_total++;
    if (req_cnt - r0 == DEPTH / 2) n_pass++;
    else $display("FAIL bp_reqs: issued %0d required %0d", req_cnt - r0, DEPTH / 2);
    n_total++;
    if (dut.count == DEPTH) n_pass++;
    else $display("FAIL bp_count: count=%0d required %0d", dut.count, DEPTH);
    n_total++;
    if (bus.mem_req === 1'b0 && bus.inst_valid === 1'b1) n_pass++;
    else $display("FAIL bp_hold: mem_req=%b valid=%b required 0 and 1", bus.mem_req, bus.inst_valid);
    run_stream(40, 60, 0, 32'h0, 1, "bp");
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    fill_img(1);
    lat = 1;
    do_reset();
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) seen = 1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (dut.count === '0 && bus.inst_valid === 1'b0) n_pass++;
    else $display("FAIL rstmid_count: count=%0d valid=%b required 0 and 0", dut.count, bus.inst_valid);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bus.mem_req === 1'b1) seen = 1;
      else @(negedge clk);
    end
    n_total++;
    if (seen && bus.mem_addr === 32'h0) n_pass++;
    else $display("FAIL rstmid_addr: seen=%0d addr=%h required 1 and 00000000", seen, bus.mem_addr);
    run_stream(20, 100, 0, 32'h0, 1, "rstmid");
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      fill_img(1);
      lat = 1 + $urandom_range(2);
      do_reset();
      if (r == 0) run_stream(150, 70, 0, 32'h0, 1, "rand_noredir");
      else        run_stream(150, 70, 4, 32'h0, 0, "rand_redir");
    end
  endtask

  initial begin
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.inst_ready  = 1'b0;
    fill_img(0);
    test_reset();
    test_16bit();
    test_32bit();
    test_split();
    test_redirect();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
